mul_share_arb: RTL and testbench

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_share_arb_pkg.sv | 33 +++
 rtl/wallace_26x24.sv | 37 +++
 rtl/mul_share_arb.sv | 115 +++++++++++
 tb/tb_mul_share_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_arb_pkg
// Shared constants and helpers for the two-requester shared multiplier.
//   M_DEF / N_DEF : default operand A / B widths
//   ID_W          : width of a requester index
//   req_id_t      : requester index type
//   rr_pick()     : round-robin grant selection between the two requesters
// -----------------------------------------------------------------------------
package mul_share_arb_pkg;

  localparam int M_DEF = 26;
  localparam int N_DEF = 24;
  localparam int ID_W  = 1;

  typedef logic [ID_W-1:0] req_id_t;

  // With both requesters asking, the one that did not win last time goes next.
  // With only one asking, it gets the grant. The caller qualifies the result
  // with (v0 | v1), so the "nobody asking" value is never used.
  function automatic req_id_t rr_pick(input logic v0, input logic v1,
                                      input req_id_t last);
    req_id_t pick;
    if (v0 && v1) begin
      pick = (last == req_id_t'(0)) ? req_id_t'(1) : req_id_t'(0);
    end else if (v1) begin
      pick = req_id_t'(1);
    end else begin
      pick = req_id_t'(0);
    end
    return pick;
  endfunction

endpackage

// File: rtl/wallace_26x24.sv
// -----------------------------------------------------------------------------
// wallace_26x24
// Purely combinational unsigned multiplier, full-width result.
//   a : input  [M-1:0]   multiplicand
//   b : input  [N-1:0]   multiplier
//   z : output [M+N-1:0] a * b, never truncated
// One partial product per bit of b, then summed at full result width so no
// carry out of the top column can be lost.
// -----------------------------------------------------------------------------
module wallace_26x24
  import mul_share_arb_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
) (
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [M+N-1:0] z
);

  logic [M+N-1:0] w_pp [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pp
      assign w_pp[gi] = b[gi] ? ({{N{1'b0}}, a} << gi) : '0;
    end
  endgenerate

  always_comb begin
    z = '0;
    for (int i = 0; i < N; i++) begin
      z = z + w_pp[i];
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
// Two requesters share one multiplier through a round-robin arbiter and a
// two-stage valid/ready pipeline (S1 = granted operands, S2 = product).
//   clk, rst                       : clock, synchronous active-high reset
//   in0_valid/ready/a/b            : requester 0 operand pair handshake
//   in1_valid/ready/a/b            : requester 1 operand pair handshake
//   out_valid/ready/p/id           : product handshake, product, source index
//   busy                           : any pipeline stage occupied
// -----------------------------------------------------------------------------
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [M-1:0]    in0_a,
  input  logic [N-1:0]    in0_b,
  input  logic            in1_valid,
  output logic            in1_ready,
  input  logic [M-1:0]    in1_a,
  input  logic [N-1:0]    in1_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M+N-1:0]  out_p,
  output logic [ID_W-1:0] out_id,
  output logic            busy
);

  // Pipeline state
  logic            r_s1_valid;
  logic [M-1:0]    r_s1_a;
  logic [N-1:0]    r_s1_b;
  req_id_t         r_s1_id;
  logic            r_out_valid;
  logic [M+N-1:0]  r_out_p;
  req_id_t         r_out_id;
  req_id_t         r_rr_last;

  logic            w_s2_load;
  logic            w_s1_load;
  logic            w_gnt_valid;
  req_id_t         w_gnt_id;
  logic            w_xfer;
  logic [M-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic [M+N-1:0]  w_prod;

  // Full-stall chain: S1 may refill only when it is empty or S2 is moving.
  assign w_s2_load   = !r_out_valid || out_ready;
  assign w_s1_load   = !r_s1_valid || w_s2_load;

  assign w_gnt_valid = in0_valid || in1_valid;
  assign w_gnt_id    = rr_pick(in0_valid, in1_valid, r_rr_last);
  assign w_xfer      = w_s1_load && w_gnt_valid;

  // Ready is forced low during reset so nothing is accepted into a flushing pipe.
  assign in0_ready   = !rst && w_xfer && (w_gnt_id == req_id_t'(0));
  assign in1_ready   = !rst && w_xfer && (w_gnt_id == req_id_t'(1));

  assign w_sel_a     = (w_gnt_id == req_id_t'(1)) ? in1_a : in0_a;
  assign w_sel_b     = (w_gnt_id == req_id_t'(1)) ? in1_b : in0_b;

  wallace_26x24 #(
    .M (M),
    .N (N)
  ) u_mul (
    .a (r_s1_a),
    .b (r_s1_b),
    .z (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_id     <= '0;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_out_id    <= '0;
      // Requester 0 wins the first contention after reset.
      r_rr_last   <= req_id_t'(1);
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= w_xfer;
        if (w_xfer) begin
          r_s1_a    <= w_sel_a;
          r_s1_b    <= w_sel_b;
          r_s1_id   <= w_gnt_id;
          r_rr_last <= w_gnt_id;
        end
      end
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        // Data only moves with a valid entry so the output holds its last
        // value while out_valid is low.
        if (r_s1_valid) begin
          r_out_p  <= w_prod;
          r_out_id <= r_s1_id;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_id    = r_out_id;
  assign busy      = r_s1_valid || r_out_valid;

endmodule

// File: tb/tb_mul_share_arb.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arb
// Self-checking bench for mul_share_arb: directed vector table, hand-written
// corner sequences (alternation, stall, reset flush) and a randomized run
// against an occupancy + in-order scoreboard reference.
// -----------------------------------------------------------------------------
module tb_mul_share_arb;

  localparam int M = 26;
  localparam int N = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           in0_valid, in1_valid;
  logic           in0_ready, in1_ready;
  logic [M-1:0]   in0_a, in1_a;
  logic [N-1:0]   in0_b, in1_b;
  logic           out_valid, out_ready;
  logic [M+N-1:0] out_p;
  logic [0:0]     out_id;
  logic           busy;

  always #5 clk = ~clk;

  mul_share_arb #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_a     (in0_a),
    .in0_b     (in0_b),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_a     (in1_a),
    .in1_b     (in1_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_id    (out_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: pipeline occupancy (one flag per stage, from the load rules)
  // plus an in-order queue of accepted products tagged with their requester.
  typedef struct {
    logic [63:0] p;
    bit          id;
  } ent_t;

  ent_t        acc_q[$];
  bit          m_v_s1  = 1'b0;
  bit          m_v_out = 1'b0;
  bit          m_rr    = 1'b1;
  int          n_acc   = 0;
  bit          smp_r0, smp_r1;
  logic [63:0] prev_p  = '0;

  // One clock: check readies and output transfer before the edge, advance the
  // reference at the edge, check valid/busy/hold after it.
  task automatic cycle();
    bit s2l, s1l, gv, g, e0, e1, was_rst;
    logic [63:0] newp;
    ent_t e;
    #1;
    was_rst = rst;
    s2l = !m_v_out || out_ready;
    s1l = !m_v_s1 || s2l;
    gv  = in0_valid || in1_valid;
    if (in0_valid && in1_valid) g = !m_rr;
    else if (in1_valid)         g = 1'b1;
    else                        g = 1'b0;
    e0 = !rst && s1l && gv && !g;
    e1 = !rst && s1l && gv && g;
    newp = g ? (64'(in1_a) * 64'(in1_b)) : (64'(in0_a) * 64'(in0_b));
    smp_r0 = in0_ready;
    smp_r1 = in1_ready;
    chk("in0_ready", 64'(in0_ready), 64'(e0));
    chk("in1_ready", 64'(in1_ready), 64'(e1));
    if (!rst && out_valid && out_ready) begin
      if (acc_q.size() == 0) begin
        chk("out_spurious", 64'(out_valid), 64'(0));
      end else begin
        e = acc_q.pop_front();
        chk("out_p", 64'(out_p), e.p);
        chk("out_id", 64'(out_id), 64'(e.id));
        $display("OUT id=%0d p=%0d", out_id, out_p);
      end
    end
    @(posedge clk);
    if (was_rst) begin
      m_v_s1  = 1'b0;
      m_v_out = 1'b0;
      m_rr    = 1'b1;
      acc_q.delete();
    end else begin
      if (s1l && gv) begin
        e.p = newp;
        e.id = g;
        acc_q.push_back(e);
        m_rr = g;
        n_acc++;
      end
      if (s2l) m_v_out = m_v_s1;
      if (s1l) m_v_s1 = gv;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_v_out));
    chk("busy", 64'(busy), 64'(m_v_s1 || m_v_out));
    if (was_rst) begin
      chk("rst_out_p", 64'(out_p), 64'(0));
      chk("rst_out_id", 64'(out_id), 64'(0));
    end else if (!out_valid) begin
      chk("hold_out_p", 64'(out_p), prev_p);
    end
    prev_p = 64'(out_p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [M-1:0]   a;
    logic [N-1:0]   b;
    logic [M+N-1:0] p;
  } vec_t;

  function automatic logic [M-1:0] rnd_a();
    case ($urandom_range(7))
      0:       return '1;
      1:       return '0;
      default: return M'($urandom());
    endcase
  endfunction

  function automatic logic [N-1:0] rnd_b();
    case ($urandom_range(7))
      0:       return '1;
      1:       return '0;
      default: return N'($urandom());
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[7];
    int   n;
    bit   pend0, pend1;
    int   cyc;

    vec[0] = '{a: 26'd3,         b: 24'd5,        p: 50'd15};
    vec[1] = '{a: 26'd0,         b: 24'hFFFFFF,   p: 50'd0};
    vec[2] = '{a: 26'h3FFFFFF,   b: 24'hFFFFFF,   p: 50'd1125899822956545};
    vec[3] = '{a: 26'd1,         b: 24'hABCDEF,   p: 50'hABCDEF};
    vec[4] = '{a: 26'h2000000,   b: 24'h800000,   p: 50'h1000000000000};
    vec[5] = '{a: 26'h3FFFFFF,   b: 24'd1,        p: 50'h3FFFFFF};
    vec[6] = '{a: 26'd1000,      b: 24'd1000,     p: 50'd1000000};

    rst = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
    cycle();
    cycle();
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_in0_ready", 64'(smp_r0), 64'(0));
    rst = 1'b0;

    // Directed vectors through requester 0, checking latency and value.
    for (int i = 0; i < 7; i++) begin
      in0_valid = 1'b1; in0_a = vec[i].a; in0_b = vec[i].b; out_ready = 1'b1;
      cycle();
      chk("vec_accept", 64'(smp_r0), 64'(1));
      in0_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 4) begin
        cycle();
        n++;
      end
      chk("vec_latency", 64'(n), 64'(1));
      chk("vec_p", 64'(out_p), 64'(vec[i].p));
      chk("vec_id", 64'(out_id), 64'(0));
    end

    // Continuous contention alternates starting with requester 0.
    do_reset();
    in0_valid = 1'b1; in0_a = 26'd7;  in0_b = 24'd9;
    in1_valid = 1'b1; in1_a = 26'd11; in1_b = 24'd13;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k >= 1) begin
        chk("alt_valid", 64'(out_valid), 64'(1));
        chk("alt_id", 64'(out_id), 64'((k - 1) % 2));
        chk("alt_p", 64'(out_p), ((k - 1) % 2 == 0) ? 64'd63 : 64'd143);
      end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    cycle(); cycle(); cycle();

    // Back-to-back inputs into a stalled output.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in0_valid = 1'b1; in0_a = M'(2 * j + 1); in0_b = N'(2 * j + 2);
      cycle();
      chk("stall_accept", 64'(smp_r0), 64'(j < 2));
    end
    for (int j = 0; j < 2; j++) begin
      cycle();
      chk("stall_ready", 64'(smp_r0), 64'(0));
      chk("stall_hold_p", 64'(out_p), 64'd2);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_accept", 64'(smp_r0), 64'(1));
    chk("drain_p2", 64'(out_p), 64'd12);
    in0_valid = 1'b0;
    cycle();
    chk("drain_p3", 64'(out_p), 64'd30);
    cycle();
    chk("drain_done", 64'(busy), 64'(0));

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_a = 26'd9; in0_b = 24'd9;
    in1_valid = 1'b1; in1_a = 26'd4; in1_b = 24'd4;
    cycle(); cycle();
    chk("full_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    cycle();
    chk("rstfull_r0", 64'(smp_r0), 64'(0));
    chk("rstfull_r1", 64'(smp_r1), 64'(0));
    chk("rstfull_out_valid", 64'(out_valid), 64'(0));
    chk("rstfull_busy", 64'(busy), 64'(0));
    rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("no_stale", 64'(out_valid), 64'(0));
    end

    // Randomized traffic on both ports with random back-pressure.
    do_reset();
    n_acc = 0; pend0 = 1'b0; pend1 = 1'b0; cyc = 0;
    while (n_acc < 1000 && cyc < 6000) begin
      if (!pend0 && $urandom_range(3) != 0) begin
        pend0 = 1'b1; in0_a = rnd_a(); in0_b = rnd_b();
      end
      if (!pend1 && $urandom_range(3) != 0) begin
        pend1 = 1'b1; in1_a = rnd_a(); in1_b = rnd_b();
      end
      in0_valid = pend0;
      in1_valid = pend1;
      out_ready = ($urandom_range(2) != 0);
      cycle();
      if (pend0 && smp_r0) pend0 = 1'b0;
      if (pend1 && smp_r1) pend1 = 1'b0;
      cyc++;
    end
    chk("rand_budget", 64'(n_acc >= 1000), 64'(1));
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      cycle();
      n++;
    end
    chk("rand_drained", 64'(busy), 64'(0));
    chk("rand_queue_empty", 64'(acc_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
